anubis_serial_rx: RTL and testbench

- Upstream receive stage of the Cmod A7 link. Deserialises one request frame from the remote board: mode bit, 128-bit data block, 128-bit key.
- Transfer uses a bit-serial 4-phase req/ack handshake.
- Presents the frame in parallel to the cipher-core register stage, with ready/take handshake.
- Holds the frame stable until the consumer takes it.

---
 rtl/anubis_link_defs.sv | 22 ++
 rtl/anubis_serial_rx_if.sv | 29 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/anubis_serial_rx.sv | 158 +++++++++++++++
 tb/tb_anubis_serial_rx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/anubis_link_defs.sv
// Shared definitions for the Anubis Cmod A7 serial link (receive and transmit).
// Contents: frame geometry, mode-bit encodings, link FSM state encoding and
// the default mid-frame timeout (100 ms at 12 MHz).
package anubis_link_defs;

    localparam int DATA_W_DEF  = 128;
    localparam int KEY_W_DEF   = 128;
    localparam int FRAME_BITS  = 1 + DATA_W_DEF + KEY_W_DEF;   // 257
    localparam int CNT_W_DEF   = 9;
    localparam int TIMEOUT_DEF = 1200000;

    localparam logic MODE_ENC = 1'b1;
    localparam logic MODE_DEC = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2,
        DONE    = 2'd3
    } link_state_t;

endpackage

// File: rtl/anubis_serial_rx_if.sv
// Link bundle between the remote serial sender, the receive stage and the
// cipher-core register stage.
//   rxd, req_in, ack_out      : bit-serial 4-phase req/ack transfer
//   data_out, key_out, encrypt: parallel frame contents
//   ready, take               : frame hand-over to the consumer
// slave  = receive stage view, master = sender/consumer view.
interface anubis_serial_rx_if #(
    parameter int DATA_W = 128,
    parameter int KEY_W  = 128
);
    logic              rxd;
    logic              req_in;
    logic              ack_out;
    logic [DATA_W-1:0] data_out;
    logic [KEY_W-1:0]  key_out;
    logic              encrypt;
    logic              ready;
    logic              take;

    modport slave (
        input  rxd, req_in, take,
        output ack_out, data_out, key_out, encrypt, ready
    );

    modport master (
        output rxd, req_in, take,
        input  ack_out, data_out, key_out, encrypt, ready
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
//   clk     : destination clock
//   reset_b : asynchronous active-low reset, clears both stages
//   d       : asynchronous inputs
//   q       : inputs synchronised to clk (2-cycle latency)
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;
endmodule

// File: rtl/anubis_serial_rx.sv
// Anubis serial receive stage: deserialises one request frame (mode bit,
// data block, key, MSB first) sent bit-serially over a 4-phase req/ack
// handshake and presents it in parallel with a ready/take hand-over.
//   clk, reset_b : system clock, asynchronous active-low reset
//   enable       : permits the start of a new frame (sampled in IDLE only)
//   busy         : a frame is in progress
//   frame_err    : one-cycle pulse when a stalled frame is aborted
//   link         : serial handshake and parallel frame outputs (slave side)
module anubis_serial_rx
    import anubis_link_defs::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int KEY_W          = KEY_W_DEF,
    parameter int CNT_W          = CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic                enable,
    output logic                busy,
    output logic                frame_err,
    anubis_serial_rx_if.slave   link
);
    localparam int FRM_W = 1 + DATA_W + KEY_W;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRM_W - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0] sync_q;
    logic       rxd_s;
    logic       req_s;

    sync_2ff #(.W(2)) u_sync (
        .clk     (clk),
        .reset_b (reset_b),
        .d       ({link.rxd, link.req_in}),
        .q       (sync_q)
    );
    assign rxd_s = sync_q[1];
    assign req_s = sync_q[0];

    link_state_t       state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;
    logic [TMO_W-1:0]  tmo_reg,   tmo_next;
    logic [FRM_W-1:0]  shift_reg, shift_next;
    logic              ack_reg,   ack_next;
    logic              ready_reg, ready_next;
    logic [DATA_W-1:0] data_reg,  data_next;
    logic [KEY_W-1:0]  key_reg,   key_next;
    logic              enc_reg,   enc_next;
    logic              err_reg,   err_next;
    logic              abort;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            tmo_reg   <= '0;
            shift_reg <= '0;
            ack_reg   <= 1'b0;
            ready_reg <= 1'b0;
            data_reg  <= '0;
            key_reg   <= '0;
            enc_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tmo_reg   <= tmo_next;
            shift_reg <= shift_next;
            ack_reg   <= ack_next;
            ready_reg <= ready_next;
            data_reg  <= data_next;
            key_reg   <= key_next;
            enc_reg   <= enc_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tmo_next   = '0;            // any state change clears the timer
        shift_next = shift_reg;
        ack_next   = ack_reg;
        ready_next = ready_reg;
        data_next  = data_reg;
        key_next   = key_reg;
        enc_next   = enc_reg;
        err_next   = 1'b0;
        abort      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (enable) state_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (req_s) begin
                    shift_next = {shift_reg[FRM_W-2:0], rxd_s};
                    ack_next   = 1'b1;
                    state_next = WAIT_LO;
                end else if (cnt_reg != '0) begin
                    // Waiting for the first bit of a frame never times out.
                    if (tmo_reg == TMO_LAST) abort = 1'b1;
                    else                     tmo_next = tmo_reg + TMO_W'(1);
                end
            end
            WAIT_LO: begin
                if (!req_s) begin
                    ack_next = 1'b0;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_BIT) begin
                        // Shift register now holds mode, data, key (MSB first).
                        state_next = DONE;
                        data_next  = shift_reg[FRM_W-2 -: DATA_W];
                        key_next   = shift_reg[KEY_W-1:0];
                        enc_next   = (shift_reg[FRM_W-1] == MODE_ENC);
                    end else begin
                        state_next = WAIT_HI;
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    abort = 1'b1;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end
            DONE: begin
                // ready follows one cycle after the outputs are loaded, so the
                // consumer never sees ready with stale data. Any req activity
                // here stays pending in the synchroniser until WAIT_HI.
                if (link.take) begin
                    ready_next = 1'b0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    ready_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (abort) begin
            err_next   = 1'b1;
            ack_next   = 1'b0;
            cnt_next   = '0;
            shift_next = '0;
            state_next = IDLE;
        end
    end

    assign busy          = ((state_reg == WAIT_HI) && (cnt_reg != '0)) || (state_reg == WAIT_LO);
    assign frame_err     = err_reg;
    assign link.ack_out  = ack_reg;
    assign link.ready    = ready_reg;
    assign link.data_out = data_reg;
    assign link.key_out  = key_reg;
    assign link.encrypt  = enc_reg;
endmodule

// File: tb/tb_anubis_serial_rx.sv
module tb_anubis_serial_rx;
    import anubis_link_defs::*;

    localparam int TMO       = 100;
    localparam int ACK_BOUND = 300;
    localparam int N_RANDOM  = 12;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    logic enable = 1'b0;
    logic busy;
    logic frame_err;

    anubis_serial_rx_if #(.DATA_W(128), .KEY_W(128)) lnk();

    anubis_serial_rx #(
        .DATA_W(128), .KEY_W(128), .CNT_W(9), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .enable    (enable),
        .busy      (busy),
        .frame_err (frame_err),
        .link      (lnk)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int err_count  = 0;
    int frames_seen = 0;

    // Expected frames as {mode, data, key}: what was sent is what must appear.
    logic [FRAME_BITS-1:0] exp_q[$];
    logic                  prev_ready = 1'b0;
    logic [FRAME_BITS-1:0] held;

    task automatic chk(input string name, input logic [FRAME_BITS-1:0] act,
                       input logic [FRAME_BITS-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor / scoreboard: checks each presented frame and that it is held.
    always @(negedge clk) begin
        logic [FRAME_BITS-1:0] e;
        logic [FRAME_BITS-1:0] got;
        if (frame_err === 1'b1) err_count++;
        got = {lnk.encrypt, lnk.data_out, lnk.key_out};
        if (reset_b && lnk.ready === 1'b1) begin
            if (!prev_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame", got, e);
                    frames_seen++;
                    $display("frame %0d: mode=%0b data=%h key=%h", frames_seen,
                             lnk.encrypt, lnk.data_out, lnk.key_out);
                end
                held = got;
            end else begin
                chk("hold_while_ready", got, held);
                chk("ack_while_ready", lnk.ack_out, 0);
            end
        end
        prev_ready = reset_b & (lnk.ready === 1'b1);
    end

    task automatic wait_ack(input logic lvl, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (lnk.ack_out !== lvl && n < ACK_BOUND);
        if (lnk.ack_out !== lvl) chk("ack_wait_expired", lnk.ack_out, lvl);
    endtask

    function automatic int pick_delay(input int fixed);
        if (fixed >= 0) return fixed;
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 0;
    endfunction

    task automatic send_bit(input logic b, input int dly, input logic lat);
        int n;
        lnk.rxd = b;
        repeat (pick_delay(dly)) @(negedge clk);
        lnk.req_in = 1'b1;
        wait_ack(1'b1, n);
        if (lat) chk("ack_rise_latency", n, 3);
        repeat (pick_delay(dly)) @(negedge clk);
        lnk.req_in = 1'b0;
        wait_ack(1'b0, n);
        if (lat) chk("ack_fall_latency", n, 3);
    endtask

    task automatic send_bits(input logic [FRAME_BITS-1:0] f, input int nbits,
                             input int dly, input logic lat, input int drop_at);
        for (int i = 0; i < nbits; i++) begin
            if (i == drop_at) enable = 1'b0;
            send_bit(f[FRAME_BITS-1-i], dly, lat);
        end
    endtask

    task automatic send_frame(input logic mode, input logic [127:0] data,
                              input logic [127:0] key, input int dly,
                              input logic lat, input int drop_at);
        logic [FRAME_BITS-1:0] f;
        f = {mode, data, key};
        exp_q.push_back(f);
        send_bits(f, FRAME_BITS, dly, lat, drop_at);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (lnk.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (lnk.ready !== 1'b1) chk("ready_wait_expired", lnk.ready, 1);
    endtask

    task automatic collect();
        wait_ready();
        @(negedge clk);
        lnk.take = 1'b1;
        @(negedge clk);
        lnk.take = 1'b0;
        chk("ready_cleared_by_take", lnk.ready, 0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base_err;
        int acks;
        lnk.rxd    = 1'b0;
        lnk.req_in = 1'b0;
        lnk.take   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {lnk.ack_out, lnk.ready, busy, frame_err, lnk.encrypt}, 0);
        chk("reset_data", lnk.data_out, 0);
        chk("reset_key", lnk.key_out, 0);
        reset_b = 1'b1;
        enable  = 1'b1;
        @(negedge clk);

        // Encrypt frame with exact ack latency checks.
        send_frame(MODE_ENC, 128'h00112233445566778899AABBCCDDEEFF,
                   128'h000102030405060708090A0B0C0D0E0F, 2, 1'b1, -1);
        wait_ready();
        chk("encrypt_flag", lnk.encrypt, 1);
        collect();

        // Reset in the middle of a frame.
        send_bits({1'b1, rand128(), rand128()}, 40, 1, 1'b0, -1);
        chk("busy_mid_frame", busy, 1);
        #2 reset_b = 1'b0;
        #1;
        chk("midreset_ctrl", {lnk.ack_out, lnk.ready, busy, frame_err, lnk.encrypt}, 0);
        chk("midreset_data", lnk.data_out, 0);
        chk("midreset_key", lnk.key_out, 0);
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        send_frame(1'b0, rand128(), rand128(), 1, 1'b0, -1);
        collect();

        // Decrypt frame, then a second frame whose first bit arrives before take.
        send_frame(MODE_DEC, {128{1'b1}}, 128'h0, 1, 1'b0, -1);
        wait_ready();
        chk("decrypt_flag", lnk.encrypt, 0);
        fork
            send_frame(1'b1, rand128(), rand128(), 3, 1'b0, -1);
            begin
                repeat (10) @(negedge clk);
                chk("no_ack_before_take", lnk.ack_out, 0);
                chk("ready_before_take", lnk.ready, 1);
                lnk.take = 1'b1;
                @(negedge clk);
                lnk.take = 1'b0;
                chk("ready_cleared_b2b", lnk.ready, 0);
            end
        join
        collect();

        // Mid-frame stall: abort after TMO cycles of waiting.
        base_err = err_count;
        send_bits({1'b0, rand128(), rand128()}, 10, 1, 1'b0, -1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_err !== 1'b1 && n < 2 * TMO);
        chk("timeout_cycle", n, TMO);
        repeat (20) @(negedge clk);
        chk("timeout_pulses", err_count - base_err, 1);
        chk("busy_after_timeout", busy, 0);
        chk("ack_after_timeout", lnk.ack_out, 0);
        send_frame(1'b1, rand128(), rand128(), 1, 1'b0, -1);
        enable = 1'b0;
        collect();

        // Enable gating in IDLE.
        acks = 0;
        for (int t = 0; t < 5; t++) begin
            lnk.req_in = 1'b1;
            repeat (6) begin
                @(negedge clk);
                if (lnk.ack_out !== 1'b0) acks++;
            end
            lnk.req_in = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (lnk.ack_out !== 1'b0) acks++;
            end
        end
        chk("ack_gated_by_enable", acks, 0);
        chk("busy_gated", busy, 0);
        enable = 1'b1;
        @(negedge clk);
        send_frame(1'b0, rand128(), rand128(), 0, 1'b0, 200);
        collect();
        enable = 1'b1;
        @(negedge clk);

        // Random contents and handshake timing.
        base_err = err_count;
        for (int k = 0; k < N_RANDOM; k++) begin
            send_frame(1'($urandom_range(0, 1)), rand128(), rand128(), -1, 1'b0, -1);
            collect();
        end
        chk("random_no_frame_err", err_count - base_err, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
